// File: rtl/conv_sequencer.sv
// Sequences one 3x3 window through the four-lane cfc MAC datapath:
// clear, 36 tap-outer/MAC-inner loads, then get, returning {mac3..mac0}.
module conv_sequencer #(
  parameter int TAPS    = 9,
  parameter int MACS    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 coef_we,
  input  logic [5:0]           coef_addr,
  input  logic [7:0]           coef_data,
  input  logic                 start,
  input  logic [TAPS*8-1:0]    pixels,
  output logic                 busy,
  output logic                 result_valid,
  output logic [MACS*8-1:0]    result,
  output logic                 error,
  output logic [1:0]           cfc_op_code,
  output logic [1:0]           cfc_index,
  output logic [7:0]           cfc_value_a,
  output logic [7:0]           cfc_value_b,
  input  logic [MACS*8-1:0]    cfc_data_out,
  input  logic                 cfc_done
);
  localparam int            NLOAD = TAPS * MACS;
  localparam int            PW    = $clog2(NLOAD + 2);
  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [PW-1:0] LAST  = PW'(NLOAD + 1);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_GET  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_e;

  state_e                        state_q;
  logic [PW-1:0]                 ptr_q, ptr_d, k;
  logic [TW-1:0]                 wcnt_q;
  logic                          busy_q, rv_q, err_q;
  logic [MACS*8-1:0]             res_q;
  logic [1:0]                    op_q, idx_q, op_d, idx_d;
  logic [7:0]                    a_q, b_q, a_d, b_d;
  logic [TAPS-1:0][7:0]          pix_q;
  logic [MACS-1:0][TAPS-1:0][7:0] coef_q;

  // A write accepted on the same edge as start must not reach the window
  // just latched, so the overwritten entry is kept aside for this sequence.
  logic       shd_vld_q;
  logic [1:0] shd_mac_q;
  logic [3:0] shd_tap_q;
  logic [7:0] shd_dat_q;

  logic [1:0] wr_mac, mac_s;
  logic [3:0] wr_tap, tap_s;
  logic       wr_en;

  assign wr_mac = coef_addr[5:4];
  assign wr_tap = coef_addr[3:0];
  assign wr_en  = coef_we && (state_q == IDLE) && (wr_tap < 4'(TAPS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   coef_q <= '0;
    else if (wr_en) coef_q[wr_mac][wr_tap] <= coef_data;
  end

  always_comb begin
    ptr_d = (state_q == IDLE) ? '0 : ptr_q + 1'b1;
    k     = ptr_d - 1'b1;
    mac_s = k[1:0];
    tap_s = k[5:2];
    op_d  = OP_GET;
    idx_d = '0;
    a_d   = '0;
    b_d   = '0;
    if (ptr_d == '0) begin
      op_d = OP_CLR;
    end else if (ptr_d <= PW'(NLOAD)) begin
      op_d  = OP_LOAD;
      idx_d = mac_s;
      a_d   = pix_q[tap_s];
      b_d   = (shd_vld_q && shd_mac_q == mac_s && shd_tap_q == tap_s) ?
              shd_dat_q : coef_q[mac_s][tap_s];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wcnt_q    <= '0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      op_q      <= OP_NOP;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pix_q     <= '0;
      shd_vld_q <= 1'b0;
      shd_mac_q <= '0;
      shd_tap_q <= '0;
      shd_dat_q <= '0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= ISSUE;
          busy_q    <= 1'b1;
          err_q     <= 1'b0;
          pix_q     <= pixels;
          ptr_q     <= ptr_d;
          op_q      <= op_d;
          idx_q     <= idx_d;
          a_q       <= a_d;
          b_q       <= b_d;
          shd_vld_q <= wr_en;
          shd_mac_q <= wr_mac;
          shd_tap_q <= wr_tap;
          shd_dat_q <= coef_q[wr_mac][wr_tap];
        end
        ISSUE: begin
          op_q    <= OP_NOP;
          state_q <= SETTLE;
        end
        SETTLE: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cfc_done) begin
            if (ptr_q == LAST) begin
              res_q   <= cfc_data_out;
              rv_q    <= 1'b1;
              busy_q  <= 1'b0;
              idx_q   <= '0;
              a_q     <= '0;
              b_q     <= '0;
              state_q <= IDLE;
            end else begin
              ptr_q   <= ptr_d;
              op_q    <= op_d;
              idx_q   <= idx_d;
              a_q     <= a_d;
              b_q     <= b_d;
              state_q <= ISSUE;
            end
          end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result       = res_q;
  assign error        = err_q;
  assign cfc_op_code  = op_q;
  assign cfc_index    = idx_q;
  assign cfc_value_a  = a_q;
  assign cfc_value_b  = b_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized bench for conv_sequencer: a cfc model answers commands, a
// scoreboard checks the command trace and results against a dot-product model.
module tb_conv_sequencer;
  logic        clock = 1'b0, reset_n = 1'b0, coef_we = 1'b0, start = 1'b0;
  logic        cfc_done = 1'b0;
  logic [5:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;
  logic [71:0] pixels = '0;
  logic [31:0] cfc_data_out = '0;
  logic        busy, result_valid, error;
  logic [31:0] result;
  logic [1:0]  cfc_op_code, cfc_index;
  logic [7:0]  cfc_value_a, cfc_value_b;

  conv_sequencer dut (
    .clock(clock), .reset_n(reset_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .start(start), .pixels(pixels), .busy(busy),
    .result_valid(result_valid), .result(result), .error(error),
    .cfc_op_code(cfc_op_code), .cfc_index(cfc_index), .cfc_value_a(cfc_value_a),
    .cfc_value_b(cfc_value_b), .cfc_data_out(cfc_data_out), .cfc_done(cfc_done)
  );

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask
  task automatic flag(input string nm);
    checks++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // reference state
  int          bank [4][9];
  logic [7:0]  pix [9];
  logic [19:0] exp_cmd_q [$];
  logic [31:0] exp_res_q [$];
  int          exp_cyc_q [$];
  logic [31:0] last_res = '0;
  int          dly = 0, hang_after = 1000, c0 = 0;

  function automatic void push_cmds();
    exp_cmd_q.push_back({2'd1, 2'd0, 16'd0});
    for (int t = 0; t < 9; t++)
      for (int m = 0; m < 4; m++) begin
        int c;
        c = bank[m][t];
        exp_cmd_q.push_back({2'd2, 2'(m), pix[t], c[7:0]});
      end
    exp_cmd_q.push_back({2'd3, 2'd0, 16'd0});
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] r;
    int s;
    r = '0;
    for (int m = 0; m < 4; m++) begin
      s = 0;
      for (int t = 0; t < 9; t++) s += int'(pix[t]) * bank[m][t];
      r[8*m +: 8] = s[7:0];
    end
    return r;
  endfunction

  // cfc model: 8-bit wrapping accumulators, done after a programmable delay
  logic [7:0] acc [4];
  int since = 1000, ncmd = 0;
  initial forever begin
    @(posedge clock); #1;
    if (cfc_op_code != 2'd0) begin
      since = 0;
      case (cfc_op_code)
        2'd1: begin for (int i = 0; i < 4; i++) acc[i] = 8'd0; ncmd = 0; end
        2'd2: begin acc[cfc_index] = acc[cfc_index] + cfc_value_a * cfc_value_b; ncmd++; end
        default: begin cfc_data_out = {acc[3], acc[2], acc[1], acc[0]}; ncmd++; end
      endcase
    end else if (since < 1000) since++;
    cfc_done = (since == 2 + dly) && (ncmd <= hang_after);
  end

  // scoreboard monitor
  logic [19:0] mon_act, mon_exp;
  logic [17:0] held = '0;
  int stab_err = 0;
  initial forever begin
    @(posedge clock); #1;
    mon_act = {cfc_op_code, cfc_index, cfc_value_a, cfc_value_b};
    if (cfc_op_code != 2'd0) begin
      if (exp_cmd_q.size() == 0) flag("cmd_extra");
      else begin
        mon_exp = exp_cmd_q.pop_front();
        if (mon_exp[19:18] == 2'd2) chk("cmd_load", 64'(mon_act), 64'(mon_exp));
        else chk("cmd_ctl", 64'(mon_act[19:16]), 64'(mon_exp[19:16]));
      end
      held = mon_act[17:0];
    end else if (busy && mon_act[17:0] !== held) stab_err++;
    if (result_valid) begin
      if (exp_res_q.size() == 0) flag("result_valid_unexpected");
      else begin
        chk("result", 64'(result), 64'(exp_res_q.pop_front()));
        chk("result_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr_coef(input int m, input int t, input int v);
    coef_we = 1'b1; coef_addr = {m[1:0], t[3:0]}; coef_data = v[7:0];
    tick();
    coef_we = 1'b0;
    if (t < 9) bank[m][t] = int'($signed(v[7:0]));
  endtask

  task automatic rnd_pix();
    for (int t = 0; t < 9; t++) pix[t] = 8'($urandom);
  endtask

  task automatic rnd_bank();
    for (int m = 0; m < 4; m++)
      for (int t = 0; t < 9; t++) wr_coef(m, t, int'($urandom_range(0, 255)));
  endtask

  task automatic run(input int d, input int h, input bit poke,
                     input bit wsame, input int wm, input int wt, input int wv);
    int n, expd;
    logic [31:0] er;
    dly = d; hang_after = h;
    push_cmds();
    er = ref_result();
    if (h >= 37) begin
      exp_res_q.push_back(er);
      exp_cyc_q.push_back(cyc + 1 + 38 * (3 + d));
      last_res = er;
    end
    c0 = cyc;
    start = 1'b1;
    for (int t = 0; t < 9; t++) pixels[8*t +: 8] = pix[t];
    if (wsame) begin coef_we = 1'b1; coef_addr = {wm[1:0], wt[3:0]}; coef_data = wv[7:0]; end
    tick();
    start = 1'b0; coef_we = 1'b0;
    for (int t = 0; t < 9; t++) pixels[8*t +: 8] = 8'($urandom);
    if (wsame && wt < 9) bank[wm][wt] = int'($signed(wv[7:0]));
    chk("busy_rise", 64'(busy), 64'(1));
    chk("error_clear", 64'(error), 64'(0));
    n = 1;
    while (busy && n < 3000) begin
      if (poke && n == 20) begin
        start = 1'b1; coef_we = 1'b1; coef_addr = {2'd2, 4'd3}; coef_data = 8'h81;
      end
      tick();
      n++;
      start = 1'b0; coef_we = 1'b0;
    end
    if (busy) flag("run_timeout");
    expd = (h >= 37) ? 1 + 38 * (3 + d) : 18 + (h + 1) * (3 + d);
    chk("duration", 64'(n), 64'(expd));
    chk("operand_hold", 64'(stab_err), 64'(0));
    stab_err = 0;
    chk("op_idle", 64'(cfc_op_code), 64'(0));
    if (h >= 37) chk("error_low", 64'(error), 64'(0));
    else begin
      chk("error_set", 64'(error), 64'(1));
      chk("result_kept", 64'(result), 64'(last_res));
      chk("abort_cmds_left", 64'(exp_cmd_q.size()), 64'(38 - (h + 2)));
      exp_cmd_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_rvalid"}, 64'(result_valid), 64'(0));
    chk({pfx, "_result"}, 64'(result), 64'(0));
    chk({pfx, "_error"}, 64'(error), 64'(0));
    chk({pfx, "_op"}, 64'({cfc_op_code, cfc_index, cfc_value_a, cfc_value_b}), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // zero bank after reset
    rnd_pix();
    run(0, 1000, 0, 0, 0, 0, 0);

    // directed centre-tap window
    for (int m = 0; m < 4; m++) wr_coef(m, 4, m + 1);
    for (int t = 0; t < 9; t++) pix[t] = 8'd0;
    pix[4] = 8'd10;
    run(0, 1000, 0, 0, 0, 0, 0);
    chk("directed_result", 64'(result), 64'(32'h281E140A));

    // tap addresses 9..15 are ignored
    wr_coef(0, 9, 8'h7f);
    wr_coef(1, 12, 8'h22);
    wr_coef(3, 15, 8'h33);
    rnd_pix();
    run(0, 1000, 0, 0, 0, 0, 0);

    // slow cfc: 5 extra cycles per command
    rnd_bank();
    rnd_pix();
    run(5, 1000, 0, 0, 0, 0, 0);

    // random windows; last one pokes start/coef_we while busy
    for (int i = 0; i < 3; i++) begin
      rnd_bank();
      rnd_pix();
      run(int'($urandom_range(0, 3)), 1000, i == 2, 0, 0, 0, 0);
    end

    // start + coef_we in the same cycle: write lands for the next window only
    begin
      int old;
      old = bank[2][4];
      rnd_pix();
      run(0, 1000, 0, 1, 2, 4, (old ^ 8'h5A) & 255);
      rnd_pix();
      run(2, 1000, 0, 0, 0, 0, 0);
    end

    // cfc stalls after command 3, then a recovery window
    rnd_pix();
    run(0, 3, 0, 0, 0, 0, 0);
    rnd_pix();
    run(1, 1000, 0, 0, 0, 0, 0);

    // asynchronous reset at cycle 50 of a window
    rnd_pix();
    dly = 0; hang_after = 1000;
    push_cmds();
    exp_res_q.push_back(ref_result());
    exp_cyc_q.push_back(cyc + 115);
    c0 = cyc;
    start = 1'b1;
    for (int t = 0; t < 9; t++) pixels[8*t +: 8] = pix[t];
    tick();
    start = 1'b0;
    while (cyc < c0 + 50) tick();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    exp_cmd_q.delete(); exp_res_q.delete(); exp_cyc_q.delete();
    stab_err = 0; last_res = '0;
    for (int m = 0; m < 4; m++) for (int t = 0; t < 9; t++) bank[m][t] = 0;
    repeat (3) tick();
    chk("midreset_hold_op", 64'(cfc_op_code), 64'(0));
    reset_n = 1'b1;
    tick();
    for (int t = 0; t < 9; t++) wr_coef(int'($urandom_range(0, 3)), t, int'($urandom_range(0, 255)));
    rnd_pix();
    run(0, 1000, 0, 0, 0, 0, 0);

    repeat (3) tick();
    if (exp_res_q.size() != 0) flag("results_missing");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequences one 3x3 convolution window through the four-MAC `cfc` datapath for the border-detection pipeline. The block holds a 4-kernel x 9-tap signed coefficient bank and latches a 9-pixel window on `start`. It then issues the `cfc` command stream: clear, 36 multiply-accumulate loads, then the concatenated read. It returns the four 8-bit kernel responses as one 32-bit word. It sits between the window buffer (upstream) and the magnitude/threshold stage (downstream), and is the only driver of the `cfc` command ports.

## Interface
- TAPS, 9, taps per kernel (window size); fixed by the window buffer.
- MACS, 4, kernels/MAC lanes; fixed by `cfc`.
- TIMEOUT, 15, consecutive WAIT cycles with `cfc_done` low before abort.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- coef_we  in  1  coefficient write strobe; ignored while `busy`.
- coef_addr  in  6  {mac[1:0], tap[3:0]}; tap values 9..15 ignored.
- coef_data  in  8  signed coefficient.
- start  in  1  begin one window; ignored while `busy`.
- pixels  in  72  tap t = pixels[8t+7:8t], unsigned; latched on accepted `start`.
- busy  out  1  sequence in progress.
- result_valid  out  1  one-cycle pulse, `result` updated.
- result  out  32  {mac3, mac2, mac1, mac0} captured from `cfc_data_out`.
- error  out  1  sticky timeout flag; cleared by next accepted `start`.
- cfc_op_code  out  2  0 = NOP, 1 = clear, 2 = load, 3 = get.
- cfc_index  out  2  MAC lane for load.
- cfc_value_a  out  8  pixel operand.
- cfc_value_b  out  8  signed coefficient operand.
- cfc_data_out  in  32  concatenated MAC results.
- cfc_done  in  1  `cfc` command-complete.

## Operation
- Reset: every output is 0; `cfc_op_code` is NOP; the coefficient bank is all 0; state is IDLE.
- States: IDLE, ISSUE, SETTLE, WAIT.
- IDLE -> ISSUE on `start`. The accepted `start` clears `error`, latches `pixels`, and sets the command pointer to 0.
- ISSUE (1 cycle): drives the command's op_code. Next state is SETTLE.
- SETTLE (1 cycle): op_code returns to NOP. `cfc_done` is ignored in this state. Next state is WAIT.
- WAIT: on `cfc_done`=1, the command pointer advances and the next state is ISSUE. After the last command, the block returns to IDLE instead.
- WAIT timeout: if `cfc_done` is low for TIMEOUT consecutive WAIT cycles, the block sets `error`, returns to IDLE, leaves `result` unchanged and does not pulse `result_valid`.
- Command stream: 38 commands, numbered 0..37.
  - Command 0 is clear (op 1).
  - Commands 1..36 are loads (op 2) in tap-outer, MAC-inner order. Command 1+4t+m uses index = m, value_a = pixel[t], value_b = coef[m][t].
  - Command 37 is get (op 3), with index 0.
- `cfc_index`, `cfc_value_a` and `cfc_value_b` are set in ISSUE and held unchanged through SETTLE and WAIT. They return to 0 in IDLE.
- On get completion, `result` <= `cfc_data_out` in the WAIT cycle where `cfc_done`=1. The arithmetic is performed inside `cfc`; this block does not modify the data.
- Coefficient writes land on the clock edge when `busy`=0 and tap<9. The bank is never modified during a sequence.
- `start` and `coef_we` in the same IDLE cycle: both take effect. The write is visible from the next window, not the latched one.

## Timing
- Take the accepted `start` as cycle 0.
- `busy` rises in cycle 1. The clear command's ISSUE is cycle 1.
- Each command takes a minimum of 3 cycles (ISSUE, SETTLE, WAIT). Every extra cycle with `cfc_done` low adds 1 cycle.
- With immediate done, the get ISSUE is cycle 112 and its WAIT is cycle 114.
- `result_valid` pulses in cycle 115, in the same cycle that `busy` falls. A `start` in cycle 115 is accepted.
- Reset mid-sequence forces all outputs to their reset values asynchronously. `cfc` sees NOP from then on.

## Test plan
- Reset → all outputs 0, `cfc_op_code`=0; a bank read-back through a full run with zero coefficients yields `result`=0.
- Set coef[m][4]=m+1 (all others 0), center pixel 10, and a `cfc` model with immediate done → `result`={40,30,20,10}, `result_valid` in cycle 115, `error`=0.
- Command trace → exactly 38 ISSUE cycles: op 1, then 36×op 2 with (index, value_a, value_b) in tap-outer/MAC-inner order, then op 3; operands stable through SETTLE/WAIT.
- Model delays done by 5 cycles per command → no error; `result_valid` in cycle 115+5·38=305.
- Model never asserts done after command 3 → `error`=1 after 15 WAIT cycles, `busy`=0, no `result_valid`, `result` unchanged; the next `start` clears `error`.
- `start` and `coef_we` while `busy` → no effect on the trace or `result`. `reset_n` low at cycle 50 → immediate reset values; a restart completes normally.
